// File: rtl/bcp_pkg.sv
// Shared types and helpers for the BCP implication path: index width default,
// scheduler state encoding and a population-count helper.
package bcp_pkg;

  localparam int ENC_SIZE_DEFAULT = 3;
  localparam int N_DEFAULT        = 2 ** ENC_SIZE_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Operates on a zero-extended 64-bit image so any vector up to 64 slots fits.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/find_first_set.sv
// Combinational priority encoder: reports the lowest set position of an
// ascending-indexed vector (position 0 has highest priority).
module find_first_set
  import bcp_pkg::*;
#(
  parameter  int EncodingSize = ENC_SIZE_DEFAULT,
  localparam int N            = 2 ** EncodingSize
) (
  input  logic [0:N-1]            vec,
  output logic [EncodingSize-1:0] idx,
  output logic                    any
);

  // Scan from the top down so the lowest set position is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = EncodingSize'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/implication_scheduler.sv
// Serialises a vector of pending implication flags into a stream of slot
// indices, lowest index first, one per accepted handshake.
module implication_scheduler
  import bcp_pkg::*;
#(
  parameter  int EncodingSize = ENC_SIZE_DEFAULT,
  localparam int N            = 2 ** EncodingSize
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [0:N-1]            req_vec,
  input  logic                    flush,
  output logic [EncodingSize-1:0] idx,
  output logic                    idx_valid,
  input  logic                    idx_ready,
  output logic [EncodingSize:0]   remaining,
  output logic                    busy,
  output logic                    done
);

  state_e                  state_q;
  logic [0:N-1]            pending_q;
  logic [EncodingSize-1:0] idx_q;
  logic                    idx_valid_q;
  logic [EncodingSize:0]   remaining_q;
  logic                    done_q;

  logic [0:N-1]            clr_mask;
  logic [0:N-1]            pending_d;
  logic [EncodingSize-1:0] load_idx, next_idx;
  logic                    load_any, next_any;

  always_comb begin
    clr_mask        = '0;
    clr_mask[idx_q] = 1'b1;
  end

  assign pending_d = pending_q & ~clr_mask;

  find_first_set #(.EncodingSize(EncodingSize)) u_ffs_load (
    .vec (req_vec),
    .idx (load_idx),
    .any (load_any)
  );

  find_first_set #(.EncodingSize(EncodingSize)) u_ffs_next (
    .vec (pending_d),
    .idx (next_idx),
    .any (next_any)
  );

  // flush outranks everything, including a coincident load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      idx_valid_q <= 1'b0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            if (load_any) begin
              pending_q   <= req_vec;
              idx_q       <= load_idx;
              idx_valid_q <= 1'b1;
              remaining_q <= (EncodingSize + 1)'(popcount(64'(req_vec)));
              state_q     <= ST_ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (idx_valid_q && idx_ready) begin
            pending_q   <= pending_d;
            remaining_q <= (EncodingSize + 1)'(popcount(64'(pending_d)));
            if (next_any) begin
              idx_q <= next_idx;
            end else begin
              idx_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign remaining = remaining_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_implication_scheduler.sv
// Directed bench for implication_scheduler with hand-computed expectations.
module tb_implication_scheduler;

  logic       clock;
  logic       reset_n;
  logic       load;
  logic [0:7] req_vec;
  logic       flush;
  logic [2:0] idx;
  logic       idx_valid;
  logic       idx_ready;
  logic [3:0] remaining;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  implication_scheduler #(.EncodingSize(3)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .req_vec   (req_vec),
    .flush     (flush),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .remaining (remaining),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  32'(busy), 0);
    check({tag, ".valid"}, 32'(idx_valid), 0);
    check({tag, ".done"},  32'(done), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    load      = 1'b0;
    req_vec   = '0;
    flush     = 1'b0;
    idx_ready = 1'b0;

    // Reset state
    #12;
    check("rst.idx", 32'(idx), 0);
    check("rst.rem", 32'(remaining), 0);
    check_idle("rst");
    reset_n = 1'b1;
    tick();

    // Two-bit vector, consumer always ready
    req_vec = 8'b1001_0000; load = 1'b1; idx_ready = 1'b1;
    tick(); load = 1'b0;
    check("t1.k.idx", 32'(idx), 0);
    check("t1.k.valid", 32'(idx_valid), 1);
    check("t1.k.rem", 32'(remaining), 2);
    check("t1.k.busy", 32'(busy), 1);
    tick();
    check("t1.k1.idx", 32'(idx), 3);
    check("t1.k1.valid", 32'(idx_valid), 1);
    check("t1.k1.rem", 32'(remaining), 1);
    tick();
    check("t1.k2.done", 32'(done), 1);
    check("t1.k2.valid", 32'(idx_valid), 0);
    check("t1.k2.busy", 32'(busy), 1);
    check("t1.k2.rem", 32'(remaining), 0);
    tick();
    check_idle("t1.k3");

    // Empty vector
    req_vec = 8'b0000_0000; load = 1'b1;
    tick(); load = 1'b0;
    check("t2.k.done", 32'(done), 1);
    check("t2.k.valid", 32'(idx_valid), 0);
    check("t2.k.rem", 32'(remaining), 0);
    tick();
    check_idle("t2.k1");

    // Back-pressure
    req_vec = 8'b0110_0000; load = 1'b1; idx_ready = 1'b0;
    tick(); load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t3.hold.idx", 32'(idx), 1);
      check("t3.hold.valid", 32'(idx_valid), 1);
      check("t3.hold.rem", 32'(remaining), 2);
      tick();
    end
    idx_ready = 1'b1;
    check("t3.stall.idx", 32'(idx), 1);
    tick();
    check("t3.r.idx", 32'(idx), 2);
    check("t3.r.rem", 32'(remaining), 1);
    tick();
    check("t3.done", 32'(done), 1);
    check("t3.done.valid", 32'(idx_valid), 0);
    tick();
    check_idle("t3.end");

    // Flush after the first acceptance
    req_vec = 8'b1000_1100; load = 1'b1; idx_ready = 1'b1;
    tick(); load = 1'b0;
    check("t4.k.idx", 32'(idx), 0);
    tick();
    idx_ready = 1'b0;
    check("t4.k1.rem", 32'(remaining), 2);
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("t4.fl.rem", 32'(remaining), 0);
    check_idle("t4.fl");
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle("t4.post");
    end

    // Flush and load on the same edge
    req_vec = 8'b1111_1111; load = 1'b1; flush = 1'b1;
    tick(); load = 1'b0; flush = 1'b0;
    check_idle("t4b");
    check("t4b.rem", 32'(remaining), 0);

    // Load while busy is ignored
    req_vec = 8'b0001_0000; load = 1'b1; idx_ready = 1'b1;
    tick();
    req_vec = 8'b1111_1111;
    check("t5.k.idx", 32'(idx), 3);
    check("t5.k.rem", 32'(remaining), 1);
    tick(); load = 1'b0;
    check("t5.done", 32'(done), 1);
    check("t5.done.valid", 32'(idx_valid), 0);
    tick();
    check_idle("t5.idle");
    load = 1'b1;
    tick(); load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t5.seq.idx", 32'(idx), 32'(i));
      check("t5.seq.valid", 32'(idx_valid), 1);
      check("t5.seq.rem", 32'(remaining), 32'(8 - i));
      tick();
    end
    check("t5.seq.done", 32'(done), 1);
    tick();
    check_idle("t5.seq.end");

    // Asynchronous reset mid-issue
    req_vec = 8'b1111_1111; load = 1'b1; idx_ready = 1'b0;
    tick(); load = 1'b0;
    tick();
    check("t6.pre.valid", 32'(idx_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6.rst.idx", 32'(idx), 0);
    check("t6.rst.rem", 32'(remaining), 0);
    check_idle("t6.rst");
    #3 reset_n = 1'b1;
    tick();
    check_idle("t6.rel");
    req_vec = 8'b1000_0000; load = 1'b1; idx_ready = 1'b1;
    tick(); load = 1'b0;
    check("t6.k.idx", 32'(idx), 0);
    check("t6.k.valid", 32'(idx_valid), 1);
    check("t6.k.rem", 32'(remaining), 1);
    tick();
    check("t6.done", 32'(done), 1);
    tick();
    check_idle("t6.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
